// File: rtl/motor_pkg.sv
// Shared constants for the motor drive path: FSM encodings, direction levels and the
// colDetect levels agreed with the collision detector.
package motor_pkg;

    localparam logic [2:0] ST_STOPPED = 3'd0;
    localparam logic [2:0] ST_DRIVE   = 3'd1;
    localparam logic [2:0] ST_BRAKE   = 3'd2;
    localparam logic [2:0] ST_REVERSE = 3'd3;
    localparam logic [2:0] ST_TURN    = 3'd4;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    localparam logic DRIVE = 1'b1;
    localparam logic STOP  = 1'b0;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/motor_drive_ctrl_pwm_gen.sv
// Free-running PWM generator with a registered output; output is high while cnt < duty.
module pwm_gen #(
    parameter int PERIOD = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] duty,
    output logic        pwm
);
    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pwm_q, pwm_d;

    always_comb begin
        cnt_d = (cnt_q == CW'(PERIOD - 1)) ? '0 : cnt_q + CW'(1);
        pwm_d = (32'(cnt_q) < duty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pwm_q <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/motor_drive_ctrl.sv
// Motor drive controller: forward drive on colDetect, timed brake/reverse/pivot manoeuvre on
// collision, dead-time gated PWM so the H-bridge never reverses under drive.
module motor_drive_ctrl
    import motor_pkg::*;
#(
    parameter int PWM_PERIOD   = 1000,
    parameter int DUTY_FWD     = 700,
    parameter int DUTY_REV     = 500,
    parameter int BRAKE_CYCLES = 5_000_000,
    parameter int REV_CYCLES   = 25_000_000,
    parameter int TURN_CYCLES  = 20_000_000,
    parameter int DEAD_CYCLES  = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic colDetect,
    output logic pwm_l,
    output logic pwm_r,
    output logic dir_l,
    output logic dir_r,
    output logic led_drive,
    output logic led_avoid,
    output logic led_stop
);
    localparam int MAX_DWELL = max3(BRAKE_CYCLES, REV_CYCLES, TURN_CYCLES);
    localparam int TW        = (MAX_DWELL > 1) ? $clog2(MAX_DWELL) : 1;

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          dir_l_q, dir_l_d, dir_r_q, dir_r_d;
    logic          led_drive_q, led_drive_d;
    logic          led_avoid_q, led_avoid_d;
    logic          led_stop_q, led_stop_d;
    logic [31:0]   duty;
    logic          dead;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOPPED: if (colDetect == DRIVE) state_d = ST_DRIVE;
            ST_DRIVE:   if (colDetect == STOP) state_d = ST_BRAKE;
            ST_BRAKE:   if (timer_q == TW'(BRAKE_CYCLES - 1)) state_d = ST_REVERSE;
            ST_REVERSE: if (timer_q == TW'(REV_CYCLES - 1)) state_d = ST_TURN;
            ST_TURN:    if (timer_q == TW'(TURN_CYCLES - 1)) state_d = ST_STOPPED;
            default:    state_d = ST_STOPPED;
        endcase

        // Only the timed manoeuvre states count; the timer restarts on every entry.
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (state_q == ST_BRAKE || state_q == ST_REVERSE || state_q == ST_TURN) begin
            timer_d = timer_q + TW'(1);
        end else begin
            timer_d = '0;
        end
    end

    always_comb begin
        dead        = (timer_q < TW'(DEAD_CYCLES));
        duty        = 32'd0;
        dir_l_d     = DIR_FWD;
        dir_r_d     = DIR_FWD;
        led_drive_d = 1'b0;
        led_avoid_d = 1'b0;
        led_stop_d  = 1'b0;
        case (state_q)
            ST_DRIVE: begin
                duty        = 32'(DUTY_FWD);
                led_drive_d = 1'b1;
            end
            ST_BRAKE: begin
                dir_l_d     = dir_l_q;
                dir_r_d     = dir_r_q;
                led_avoid_d = 1'b1;
            end
            ST_REVERSE: begin
                duty        = dead ? 32'd0 : 32'(DUTY_REV);
                dir_l_d     = DIR_REV;
                dir_r_d     = DIR_REV;
                led_avoid_d = 1'b1;
            end
            ST_TURN: begin
                duty        = dead ? 32'd0 : 32'(DUTY_REV);
                dir_r_d     = DIR_REV;
                led_avoid_d = 1'b1;
            end
            default: led_stop_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_STOPPED;
            timer_q     <= '0;
            dir_l_q     <= DIR_FWD;
            dir_r_q     <= DIR_FWD;
            led_drive_q <= 1'b0;
            led_avoid_q <= 1'b0;
            led_stop_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            dir_l_q     <= dir_l_d;
            dir_r_q     <= dir_r_d;
            led_drive_q <= led_drive_d;
            led_avoid_q <= led_avoid_d;
            led_stop_q  <= led_stop_d;
        end
    end

    // Both generators share reset and period, so left and right stay phase-aligned.
    pwm_gen #(.PERIOD(PWM_PERIOD)) u_pwm_l (.clk(clk), .rst(rst), .duty(duty), .pwm(pwm_l));
    pwm_gen #(.PERIOD(PWM_PERIOD)) u_pwm_r (.clk(clk), .rst(rst), .duty(duty), .pwm(pwm_r));

    assign dir_l     = dir_l_q;
    assign dir_r     = dir_r_q;
    assign led_drive = led_drive_q;
    assign led_avoid = led_avoid_q;
    assign led_stop  = led_stop_q;

endmodule

// File: tb/tb_motor_drive_ctrl.sv
// Randomised bench for motor_drive_ctrl: a schedule-based reference model predicts every
// output cycle into a queue; a monitor pops and compares after each clock edge.
module tb_motor_drive_ctrl;
    localparam int P  = 10;
    localparam int DF = 7;
    localparam int DR = 5;
    localparam int B  = 20;
    localparam int R  = 40;
    localparam int T  = 30;
    localparam int D  = 4;

    // Output vector order: {pwm_l, pwm_r, dir_l, dir_r, led_drive, led_avoid, led_stop}
    localparam logic [6:0] RESET_OUT = 7'b0011001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic colDetect = 1'b0;
    logic pwm_l, pwm_r, dir_l, dir_r, led_drive, led_avoid, led_stop;

    logic [6:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Model: mode 0 = stopped, 1 = driving, 2 = manoeuvre; m_e counts cycles since brake entry.
    int   m_mode = 0;
    int   m_e    = 0;
    int   m_cnt  = 0;
    logic m_dir_l = 1'b1;
    logic m_dir_r = 1'b1;

    always #5 clk = ~clk;

    motor_drive_ctrl #(
        .PWM_PERIOD(P), .DUTY_FWD(DF), .DUTY_REV(DR),
        .BRAKE_CYCLES(B), .REV_CYCLES(R), .TURN_CYCLES(T), .DEAD_CYCLES(D)
    ) dut (
        .clk(clk), .rst(rst), .colDetect(colDetect),
        .pwm_l(pwm_l), .pwm_r(pwm_r), .dir_l(dir_l), .dir_r(dir_r),
        .led_drive(led_drive), .led_avoid(led_avoid), .led_stop(led_stop)
    );

    function automatic logic [6:0] model_out();
        int   duty;
        logic dl, dr, p;
        logic [2:0] led;
        duty = 0;
        dl   = 1'b1;
        dr   = 1'b1;
        led  = 3'b001;
        if (m_mode == 1) begin
            duty = DF;
            led  = 3'b100;
        end else if (m_mode == 2) begin
            led = 3'b010;
            if (m_e < B) begin
                dl = m_dir_l;
                dr = m_dir_r;
            end else if (m_e < B + R) begin
                dl   = 1'b0;
                dr   = 1'b0;
                duty = (m_e - B < D) ? 0 : DR;
            end else begin
                dr   = 1'b0;
                duty = (m_e - B - R < D) ? 0 : DR;
            end
        end
        p = (m_cnt < duty);
        return {p, p, dl, dr, led};
    endfunction

    // Drives one clock's inputs, predicts the outputs after that edge, then advances the model.
    task automatic step(input logic r, input logic c);
        logic [6:0] e;
        @(negedge clk);
        rst       = r;
        colDetect = c;
        e = r ? RESET_OUT : model_out();
        m_dir_l = e[4];
        m_dir_r = e[3];
        exp_q.push_back(e);
        if (r) begin
            m_mode = 0;
            m_e    = 0;
            m_cnt  = 0;
        end else begin
            m_cnt = (m_cnt + 1) % P;
            case (m_mode)
                0: if (c) m_mode = 1;
                1: if (!c) begin
                    m_mode = 2;
                    m_e    = 0;
                end
                default: begin
                    m_e = m_e + 1;
                    if (m_e == B + R + T) begin
                        m_mode = 0;
                        m_e    = 0;
                    end
                end
            endcase
        end
    endtask

    // Monitor: compare every predicted cycle, plus the dead-time rule on reversing direction changes.
    initial begin
        logic [6:0] e, got;
        logic [1:0] prev_dir;
        int since;
        logic guarded;
        prev_dir = 2'b11;
        since    = 1000;
        guarded  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {pwm_l, pwm_r, dir_l, dir_r, led_drive, led_avoid, led_stop};
                n_tests++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t got=%b exp=%b", $time, got, e);
                end
                if ({dir_l, dir_r} !== prev_dir) begin
                    since   = 0;
                    guarded = ({dir_l, dir_r} !== 2'b11);
                end else begin
                    since++;
                end
                prev_dir = {dir_l, dir_r};
                if (guarded && since < D) begin
                    n_tests++;
                    if (pwm_l !== 1'b0 || pwm_r !== 1'b0) begin
                        n_fail++;
                        $display("FAIL dead_time t=%0t pwm=%b%b since_dir_change=%0d req=00",
                                 $time, pwm_l, pwm_r, since);
                    end
                end
            end
        end
    end

    initial begin
        int kind, len;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0);
        for (int ep = 0; ep < 16; ep++) begin
            kind = ep % 4;
            len  = $urandom_range(15, 40);
            for (int i = 0; i < len; i++) step(1'b0, 1'b1);
            step(1'b0, 1'b0);
            if (kind == 3) begin
                len = B + $urandom_range(1, R - 2);
                for (int i = 0; i < len; i++) step(1'b0, 1'($urandom_range(0, 1)));
                len = $urandom_range(1, 2);
                for (int i = 0; i < len; i++) step(1'b1, 1'($urandom_range(0, 1)));
                for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
            end else begin
                len = B + R + T + $urandom_range(0, 6);
                for (int i = 0; i < len; i++) begin
                    case (kind)
                        0:       step(1'b0, 1'b0);
                        1:       step(1'b0, 1'($urandom_range(0, 1)));
                        default: step(1'b0, 1'b1);
                    endcase
                end
                for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
            end
        end
        repeat (2) @(posedge clk);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain left=%0d req=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
